lfsr_stream: RTL and testbench
==============================

# lfsr_stream

Parametrised Fibonacci LFSR pseudo-random source with a seed-load port, a ready/valid output stream, a zero-seed guard and hardware period measurement. It replaces the fixed 8-bit random-number register in the digital-circuits lab designs. Downstream blocks either sample it every cycle (free-run mode) or pull one value per handshake (on-demand mode).

## Interface
- WIDTH, 8: state and output width; legal range 3..32.
- TAPS, 8'h1D: feedback mask (WIDTH bits). TAPS[0] must be 1. The default gives x^8+x^4+x^3+x^2+1, which is maximal with period 255.
- INIT, 8'h01: reset value and zero-seed substitute (WIDTH bits). Must be non-zero.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  load seed this cycle.
- seed  in  WIDTH  seed value, sampled when load=1.
- mode  in  1  0 = free-run (advance every cycle), 1 = on-demand (advance on handshake).
- out_ready  in  1  consumer ready.
- out_valid  out  1  out_data valid.
- out_data  out  WIDTH  current LFSR state.
- lockup  out  1  sticky flag: a zero seed was substituted.
- wrap  out  1  one-cycle pulse: the state has returned to the start value.
- period  out  WIDTH  step count of the last completed cycle; 0 until the first wrap.

## Operation
- Feedback: fb = XOR-reduce(state & TAPS). Next state = {fb, state[WIDTH-1:1]}, a right shift with the new MSB.
- Registers: state, start (value at the last load or reset), step_cnt (WIDTH bits), period, lockup, out_valid, wrap.
- advance = !load && out_valid && (mode==0 || out_ready).
- Load has priority over advance:
  - seed != 0: state <= seed, start <= seed, lockup <= 0.
  - seed == 0: state <= INIT, start <= INIT, lockup <= 1.
  - In both cases step_cnt <= 0 and wrap <= 0. period keeps its value.
- On advance:
  - If next state == start: wrap <= 1, period <= step_cnt+1, step_cnt <= 0.
  - Otherwise: step_cnt <= step_cnt+1, wrap <= 0.
- No advance and no load: state, step_cnt, period and lockup hold; wrap <= 0.
- out_data = state, driven directly from the register with no combinational path from the inputs.
- Free-run mode: values not accepted while out_ready=0 are dropped. The consumer must not expect back-pressure.
- On-demand mode: out_data is stable while out_valid && !out_ready.
- A mode change takes effect in the same cycle. State, start and step_cnt are preserved across the change.

## Timing
- Reset (asynchronous assert, synchronous release at a clk edge):
  - state = INIT, start = INIT.
  - out_valid = 0, lockup = 0, wrap = 0, period = 0, step_cnt = 0.
- out_valid goes to 1 at the first rising edge with rst=0 and stays 1. No advance occurs on that edge.
- Latency:
  - Load: seed appears on out_data 1 cycle after the load edge.
  - Advance: next value appears the cycle after the advancing edge.
- wrap is asserted in the same cycle that out_data shows the start value again.
- A load in the same cycle as a handshake: the handshake is consumed, the state is not stepped, and the loaded seed is shown next cycle.
- rst asserted mid-run clears everything immediately, without waiting for a clk edge.
- Tap mask with TAPS[0]=1: the map is invertible, so a non-zero state never reaches 0 and the state always returns to start within 2^WIDTH-1 steps.

## Test plan
- Reset then free-run, defaults: after rst falls, out_valid rises on the first edge. out_data then follows 01, 80, 40, 20, 10, 88 on successive cycles; lockup=0, wrap=0.
- Period measurement: free-run from reset. wrap pulses for exactly 1 cycle after 255 advances, with out_data=01 and period=255. The next wrap follows 255 cycles later.
- On-demand back-pressure: mode=1, out_ready toggles 1,0,0,1. out_data holds while ready=0 and advances only on handshake cycles, visiting 01, 80, 40.
- Zero-seed guard: load=1 with seed=00. The next cycle shows out_data=01 and lockup=1. A later load with seed=5A gives out_data=5A, lockup=0, and step_cnt restarts so the next wrap arrives 255 steps later.
- Load vs handshake collision: mode=1, out_ready=1 and load=1 with seed=C3 in the same cycle. Next cycle out_data=C3, not the stepped value. One more handshake gives E1.
- Mid-run reset: assert rst between clock edges during free-run. out_valid, wrap, lockup and period drop to 0 and out_data=01 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR pseudo-random source with seed load, zero-seed guard and period measurement.
// Latency: a load or an advance shows on out_data one cycle after the edge; out_data comes straight from a flop.
// Backpressure: free-run mode ignores out_ready and drops unaccepted values; on-demand mode holds out_data until out_ready.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   load, seed      seed load strobe and value (a zero seed is replaced by INIT and flagged)
//   mode            0 = free-run (step every cycle), 1 = on-demand (step on out_valid && out_ready)
//   out_ready       consumer ready
//   out_valid       out_data valid (rises on the first edge after reset)
//   out_data        current LFSR state
//   lockup          sticky: the last load carried a zero seed
//   wrap            one-cycle pulse while out_data shows the start value again
//   period          step count of the last completed cycle, 0 until the first wrap
module lfsr_stream #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
   parameter logic [WIDTH-1:0] INIT  = 8'h01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             mode,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             lockup,
   output logic             wrap,
   output logic [WIDTH-1:0] period
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] state_q,    state_d;
   logic [WIDTH-1:0] start_q,    start_d;
   logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
   logic [WIDTH-1:0] period_q,   period_d;
   logic             lockup_q,   lockup_d;
   logic             out_valid_q, out_valid_d;
   logic             wrap_q,     wrap_d;

   logic             fb;
   logic [WIDTH-1:0] next_state;
   logic             advance;
   logic             seed_zero;

   // Feedback from the tapped bits; the new bit enters at the MSB.
   assign fb         = ^(state_q & TAPS);
   assign next_state = {fb, state_q[WIDTH-1:1]};

   // out_valid is part of the condition so the edge that releases reset
   // only raises out_valid and never steps the state.
   assign advance   = !load && out_valid_q && (!mode || out_ready);
   assign seed_zero = (seed == ZERO);

   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      step_cnt_d  = step_cnt_q;
      period_d    = period_q;
      lockup_d    = lockup_q;
      out_valid_d = 1'b1;
      wrap_d      = 1'b0;

      if (load) begin
         // A zero seed would lock the register at zero forever, so it is
         // replaced by INIT and the substitution is reported on lockup.
         if (seed_zero) begin
            state_d  = INIT;
            start_d  = INIT;
            lockup_d = 1'b1;
         end else begin
            state_d  = seed;
            start_d  = seed;
            lockup_d = 1'b0;
         end
         step_cnt_d = ZERO;
      end else if (advance) begin
         state_d = next_state;
         if (next_state == start_q) begin
            // Registered together with state, so wrap lines up with the
            // cycle in which out_data shows the start value again.
            wrap_d     = 1'b1;
            period_d   = step_cnt_q + ONE;
            step_cnt_d = ZERO;
         end else begin
            step_cnt_d = step_cnt_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         start_q     <= INIT;
         step_cnt_q  <= ZERO;
         period_q    <= ZERO;
         lockup_q    <= 1'b0;
         out_valid_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         step_cnt_q  <= step_cnt_d;
         period_q    <= period_d;
         lockup_q    <= lockup_d;
         out_valid_q <= out_valid_d;
         wrap_q      <= wrap_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = state_q;
   assign lockup    = lockup_q;
   assign wrap      = wrap_q;
   assign period    = period_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream with default parameters (x^8+x^4+x^3+x^2+1, INIT=01).
// A polynomial-level reference model is compared against every output on each falling edge,
// and directed scenarios add hand-computed literal expectations.
module tb_lfsr_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] seed;
   logic       mode;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       lockup;
   logic       wrap;
   logic [7:0] period;

   int n_total = 0;
   int n_pass  = 0;
   bit done    = 1'b0;

   lfsr_stream dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .seed      (seed),
      .mode      (mode),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .lockup    (lockup),
      .wrap      (wrap),
      .period    (period)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Polynomial x^8+x^4+x^3+x^2+1 as a recurrence: the incoming bit is the
   // parity of the state bits that correspond to the polynomial's exponents 0,2,3,4.
   int poly_bits[4] = '{0, 2, 3, 4};

   function automatic int poly_next(input int s);
      int b = 0;
      foreach (poly_bits[k]) b ^= (s >> poly_bits[k]) & 1;
      return (b << 7) | (s >> 1);
   endfunction

   int m_state, m_start, m_steps, m_period;
   bit m_lock, m_valid, m_wrap;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state = 1; m_start = 1; m_steps = 0; m_period = 0;
         m_lock = 0; m_valid = 0; m_wrap = 0;
      end else begin
         m_wrap = 0;
         if (load) begin
            m_lock  = (seed == 0);
            m_state = (seed == 0) ? 1 : int'(seed);
            m_start = m_state;
            m_steps = 0;
         end else if (m_valid && (!mode || out_ready)) begin
            m_state = poly_next(m_state);
            m_steps++;
            if (m_state == m_start) begin
               m_wrap   = 1;
               m_period = m_steps;
               m_steps  = 0;
            end
         end
         m_valid = 1;
      end
   end

   always @(negedge clk) begin
      if (!done) begin
         check("model out_valid", 32'(out_valid), 32'(m_valid));
         check("model out_data",  32'(out_data),  32'(m_state));
         check("model lockup",    32'(lockup),    32'(m_lock));
         check("model wrap",      32'(wrap),      32'(m_wrap));
         check("model period",    32'(period),    32'(m_period));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_wrap(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         n++;
         if (wrap) break;
      end
      if (!wrap) $display("FAIL wrap_timeout: no wrap after %0d steps", n);
   endtask

   logic [7:0] exp_seq [6];
   int n;

   initial begin
      exp_seq[0] = 8'h01; exp_seq[1] = 8'h80; exp_seq[2] = 8'h40;
      exp_seq[3] = 8'h20; exp_seq[4] = 8'h10; exp_seq[5] = 8'h88;

      rst = 1'b1; load = 1'b0; seed = 8'h00; mode = 1'b0; out_ready = 1'b0;
      repeat (3) step();
      check("reset out_valid", 32'(out_valid), 0);
      check("reset out_data",  32'(out_data),  32'h01);
      check("reset period",    32'(period),    0);
      check("reset lockup",    32'(lockup),    0);

      // Reset then free-run: first edge only raises out_valid.
      rst = 1'b0;
      step();
      check("first edge valid", 32'(out_valid), 1);
      check("seq[0]", 32'(out_data), 32'(exp_seq[0]));
      for (int i = 1; i < 6; i++) begin
         step();
         check($sformatf("seq[%0d]", i), 32'(out_data), 32'(exp_seq[i]));
         check("seq wrap low", 32'(wrap), 0);
      end

      // Period measurement: 5 advances done, 250 more to the first wrap.
      run_until_wrap(n);
      check("first wrap steps", 32'(n), 250);
      check("first wrap data", 32'(out_data), 32'h01);
      check("first wrap period", 32'(period), 255);
      run_until_wrap(n);
      check("second wrap steps", 32'(n), 255);

      // On-demand with ready pattern 1,0,0,1 from state 01.
      mode = 1'b1; out_ready = 1'b1;
      step(); check("od handshake 1", 32'(out_data), 32'h80);
      out_ready = 1'b0;
      step(); check("od hold 1", 32'(out_data), 32'h80);
      step(); check("od hold 2", 32'(out_data), 32'h80);
      out_ready = 1'b1;
      step(); check("od handshake 2", 32'(out_data), 32'h40);
      out_ready = 1'b0;

      // Zero-seed guard, then a real seed restarts the step count.
      load = 1'b1; seed = 8'h00;
      step();
      check("zero seed data", 32'(out_data), 32'h01);
      check("zero seed lockup", 32'(lockup), 1);
      check("zero seed period kept", 32'(period), 255);
      seed = 8'h5A;
      step();
      check("seed 5A data", 32'(out_data), 32'h5A);
      check("seed 5A lockup", 32'(lockup), 0);
      load = 1'b0; mode = 1'b0;
      run_until_wrap(n);
      check("5A wrap steps", 32'(n), 255);
      check("5A wrap data", 32'(out_data), 32'h5A);

      // Load colliding with a handshake.
      mode = 1'b1; out_ready = 1'b1; load = 1'b1; seed = 8'hC3;
      step();
      check("collision data", 32'(out_data), 32'hC3);
      load = 1'b0;
      step();
      check("after collision", 32'(out_data), 32'hE1);
      out_ready = 1'b0;

      // Mid-run asynchronous reset with lockup and period non-zero.
      load = 1'b1; seed = 8'h00;
      step();
      load = 1'b0; mode = 1'b0;
      repeat (3) step();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async rst out_valid", 32'(out_valid), 0);
      check("async rst out_data",  32'(out_data),  32'h01);
      check("async rst lockup",    32'(lockup),    0);
      check("async rst wrap",      32'(wrap),      0);
      check("async rst period",    32'(period),    0);
      step();
      rst = 1'b0;
      repeat (3) step();
      check("post rst data", 32'(out_data), 32'h40);

      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
